// File: rtl/jtag_axi_txn_dispatch.sv
// jtag_axi_txn_dispatch: runs one debug request as a single-beat AXI4 read
// or write, with a timeout guard and a small status FIFO for the JTAG side.
// Ports: clk_axi/ares_axi; req_* request handshake and fields; AXI master
// AW/W/B/AR/R channels; sts_* FIFO head, pop and occupancy.
module jtag_axi_txn_dispatch #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int STS_DEPTH      = 4
) (
  input  logic                         clk_axi,
  input  logic                         ares_axi,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic                         req_write_i,
  input  logic [ADDR_W-1:0]            req_addr_i,
  input  logic [DATA_W-1:0]            req_data_i,
  input  logic [DATA_W/8-1:0]          req_wstrb_i,
  input  logic [2:0]                   req_size_i,
  output logic                         awvalid_o,
  input  logic                         awready_i,
  output logic [ADDR_W-1:0]            awaddr_o,
  output logic [2:0]                   awsize_o,
  output logic                         wvalid_o,
  input  logic                         wready_i,
  output logic [DATA_W-1:0]            wdata_o,
  output logic [DATA_W/8-1:0]          wstrb_o,
  output logic                         wlast_o,
  input  logic                         bvalid_i,
  output logic                         bready_o,
  input  logic [1:0]                   bresp_i,
  output logic                         arvalid_o,
  input  logic                         arready_i,
  output logic [ADDR_W-1:0]            araddr_o,
  output logic [2:0]                   arsize_o,
  input  logic                         rvalid_i,
  output logic                         rready_o,
  input  logic [DATA_W-1:0]            rdata_i,
  input  logic [1:0]                   rresp_i,
  input  logic                         rlast_i,
  output logic                         sts_valid_o,
  input  logic                         sts_pop_i,
  output logic [DATA_W-1:0]            sts_data_o,
  output logic [1:0]                   sts_resp_o,
  output logic                         sts_timeout_o,
  output logic                         sts_write_o,
  output logic [$clog2(STS_DEPTH+1)-1:0] sts_slots_o
);
  localparam int SW = DATA_W / 8;
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam int PW = $clog2(STS_DEPTH);
  localparam int OW = $clog2(STS_DEPTH + 1);
  localparam int EW = DATA_W + 4;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_PUSH
  } state_t;

  state_t            state_q, state_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic [SW-1:0]     strb_q, strb_d;
  logic [2:0]        size_q, size_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              to_q, to_d;
  logic [1:0]        resp_q, resp_d;
  logic [DATA_W-1:0] rdat_q, rdat_d;
  logic [EW-1:0]     mem_q [STS_DEPTH];
  logic [EW-1:0]     mem_d [STS_DEPTH];
  logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [OW-1:0]     occ_q, occ_d;
  logic              push, pop, tmo, accept;
  logic [EW-1:0]     head;
  logic              unused_ok;

  assign unused_ok = rlast_i;

  assign req_ready_o = (state_q == S_IDLE) &&
                       (occ_q < OW'(STS_DEPTH));
  assign accept = req_valid_i && req_ready_o;
  // Saturates at the last allowed cycle; tmo then holds until PUSH.
  assign tmo = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  assign awvalid_o = (state_q == S_WR) && !aw_done_q;
  assign wvalid_o  = (state_q == S_WR) && !w_done_q;
  assign bready_o  = (state_q == S_WR_RESP);
  assign arvalid_o = (state_q == S_RD_ADDR);
  assign rready_o  = (state_q == S_RD_DATA);
  assign awaddr_o  = addr_q;
  assign araddr_o  = addr_q;
  assign awsize_o  = size_q;
  assign arsize_o  = size_q;
  assign wdata_o   = wdat_q;
  assign wstrb_o   = strb_q;
  assign wlast_o   = 1'b1;

  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdat_d    = wdat_q;
    strb_d    = strb_q;
    size_d    = size_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    cnt_d     = cnt_q;
    to_d      = to_q;
    resp_d    = resp_q;
    rdat_d    = rdat_q;
    push      = 1'b0;
    if (state_q != S_IDLE && state_q != S_PUSH && !tmo)
      cnt_d = cnt_q + 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          write_d   = req_write_i;
          addr_d    = req_addr_i;
          wdat_d    = req_data_i;
          strb_d    = req_wstrb_i;
          size_d    = req_size_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          cnt_d     = '0;
          to_d      = 1'b0;
          resp_d    = 2'b00;
          rdat_d    = '0;
          state_d   = req_write_i ? S_WR : S_RD_ADDR;
        end
      end
      S_WR: begin
        if (awvalid_o && awready_i) aw_done_d = 1'b1;
        if (wvalid_o && wready_i)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = S_WR_RESP;
        else if (tmo)              state_d = S_PUSH;
      end
      S_WR_RESP: begin
        if (bvalid_i) begin
          resp_d  = bresp_i;
          rdat_d  = '0;
          state_d = S_PUSH;
        end else if (tmo) begin
          state_d = S_PUSH;
        end
      end
      S_RD_ADDR: begin
        if (arready_i) state_d = S_RD_DATA;
        else if (tmo)  state_d = S_PUSH;
      end
      S_RD_DATA: begin
        if (rvalid_i) begin
          resp_d  = rresp_i;
          rdat_d  = rdata_i;
          state_d = S_PUSH;
        end else if (tmo) begin
          state_d = S_PUSH;
        end
      end
      S_PUSH: begin
        push    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort: any busy state leaving for PUSH without a response.
    if (state_q != S_IDLE && state_q != S_PUSH &&
        state_d == S_PUSH && tmo &&
        !(state_q == S_WR_RESP && bvalid_i) &&
        !(state_q == S_RD_DATA && rvalid_i)) begin
      to_d   = 1'b1;
      resp_d = 2'b10;
      rdat_d = '0;
    end
  end

  assign pop  = sts_pop_i && (occ_q != '0);
  assign head = mem_q[rd_q];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    occ_d = occ_q;
    if (push) begin
      mem_d[wr_q] = {write_q, to_q, resp_q, rdat_q};
      wr_d        = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    if (push && !pop)      occ_d = occ_q + 1'b1;
    else if (pop && !push) occ_d = occ_q - 1'b1;
  end

  assign sts_valid_o   = (occ_q != '0);
  assign sts_slots_o   = occ_q;
  assign sts_write_o   = sts_valid_o & head[EW-1];
  assign sts_timeout_o = sts_valid_o & head[EW-2];
  assign sts_resp_o    = sts_valid_o ? head[EW-3:EW-4] : 2'b00;
  assign sts_data_o    = sts_valid_o ? head[DATA_W-1:0] : '0;

  always_ff @(posedge clk_axi) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_axi) begin
    if (ares_axi) begin
      state_q   <= S_IDLE;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdat_q    <= '0;
      strb_q    <= '0;
      size_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      cnt_q     <= '0;
      to_q      <= 1'b0;
      resp_q    <= 2'b00;
      rdat_q    <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      occ_q     <= '0;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdat_q    <= wdat_d;
      strb_q    <= strb_d;
      size_q    <= size_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      resp_q    <= resp_d;
      rdat_q    <= rdat_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      occ_q     <= occ_d;
    end
  end
endmodule

// File: tb/tb_jtag_axi_txn_dispatch.sv
// tb_jtag_axi_txn_dispatch: directed stimulus with an AXI slave driver and
// a queue-based status FIFO model checked every cycle.
module tb_jtag_axi_txn_dispatch;
  localparam int T = 16;
  localparam int D = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic ares_axi;
  logic req_valid_i, req_ready_o, req_write_i;
  logic [31:0] req_addr_i, req_data_i;
  logic [3:0] req_wstrb_i;
  logic [2:0] req_size_i;
  logic awvalid_o, awready_i, wvalid_o, wready_i, wlast_o;
  logic [31:0] awaddr_o, wdata_o, araddr_o, rdata_i;
  logic [2:0] awsize_o, arsize_o;
  logic [3:0] wstrb_o;
  logic bvalid_i, bready_o, arvalid_o, arready_i;
  logic rvalid_i, rready_o, rlast_i;
  logic [1:0] bresp_i, rresp_i, sts_resp_o;
  logic sts_valid_o, sts_pop_i, sts_timeout_o, sts_write_o;
  logic [31:0] sts_data_o;
  logic [2:0] sts_slots_o;

  jtag_axi_txn_dispatch #(
    .ADDR_W(32), .DATA_W(32),
    .TIMEOUT_CYCLES(T), .STS_DEPTH(D)
  ) dut (
    .clk_axi(clk), .ares_axi(ares_axi),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_write_i(req_write_i), .req_addr_i(req_addr_i),
    .req_data_i(req_data_i), .req_wstrb_i(req_wstrb_i),
    .req_size_i(req_size_i),
    .awvalid_o(awvalid_o), .awready_i(awready_i),
    .awaddr_o(awaddr_o), .awsize_o(awsize_o),
    .wvalid_o(wvalid_o), .wready_i(wready_i),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o),
    .bvalid_i(bvalid_i), .bready_o(bready_o), .bresp_i(bresp_i),
    .arvalid_o(arvalid_o), .arready_i(arready_i),
    .araddr_o(araddr_o), .arsize_o(arsize_o),
    .rvalid_i(rvalid_i), .rready_o(rready_o),
    .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i),
    .sts_valid_o(sts_valid_o), .sts_pop_i(sts_pop_i),
    .sts_data_o(sts_data_o), .sts_resp_o(sts_resp_o),
    .sts_timeout_o(sts_timeout_o), .sts_write_o(sts_write_o),
    .sts_slots_o(sts_slots_o)
  );

  typedef struct packed {
    logic w;
    logic to;
    logic [1:0] resp;
    logic [31:0] data;
  } ent_t;

  ent_t exp_q[$];
  ent_t pend_q[$];
  int   pend_due[$];
  int   cyc = 0;
  int   vecs = 0;
  int   errs = 0;
  int   aw_hs, w_hs;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    vecs++;
    errs++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  task automatic sched(input ent_t e, input int due);
    pend_q.push_back(e);
    pend_due.push_back(due);
  endtask

  // Model: entry visible one edge after the response edge; pop removes
  // the head present before the edge; reset drops everything.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (ares_axi) begin
      exp_q.delete();
      pend_q.delete();
      pend_due.delete();
    end else begin
      if (sts_pop_i && exp_q.size() > 0) void'(exp_q.pop_front());
      while (pend_due.size() > 0 && pend_due[0] == cyc) begin
        exp_q.push_back(pend_q.pop_front());
        void'(pend_due.pop_front());
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (cyc > 0) begin
      chk("slots", sts_slots_o, exp_q.size());
      chk("valid", sts_valid_o, exp_q.size() != 0);
      if (exp_q.size() > 0)
        chk("head", {sts_write_o, sts_timeout_o, sts_resp_o,
                     sts_data_o}, exp_q[0]);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pop1;
    sts_pop_i = 1'b1;
    tick;
    sts_pop_i = 1'b0;
  endtask

  task automatic send(input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    req_valid_i = 1'b1;
    req_write_i = w;
    req_addr_i  = a;
    req_data_i  = d;
    req_wstrb_i = s;
    req_size_i  = 3'd2;
    while (!req_ready_o && n < 200) begin
      tick;
      n++;
    end
    if (!req_ready_o) bound_fail("req_accept");
    tick;
    req_valid_i = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int awd,
                          input int wd, input logic [1:0] br,
                          input bit no_b);
    int k = 0;
    bit ad = 0, wdn = 0;
    aw_hs = 0;
    w_hs = 0;
    send(1'b1, a, d, s);
    chk("awvalid_start", awvalid_o, 1);
    chk("wvalid_start", wvalid_o, 1);
    chk("awaddr", awaddr_o, a);
    chk("awsize", awsize_o, 3'd2);
    chk("wdata", wdata_o, d);
    chk("wstrb", wstrb_o, s);
    chk("wlast", wlast_o, 1);
    while (!(ad && wdn) && k < 100) begin
      awready_i = (k >= awd);
      wready_i  = (k >= wd);
      if (!ad) chk("awvalid_hold", awvalid_o, 1);
      if (!wdn) chk("wvalid_hold", wvalid_o, 1);
      if (awvalid_o && awready_i) begin aw_hs++; ad = 1; end
      if (wvalid_o && wready_i) begin w_hs++; wdn = 1; end
      tick;
      k++;
    end
    if (!(ad && wdn)) bound_fail("aw_w_phase");
    awready_i = 1'b0;
    wready_i  = 1'b0;
    chk("awvalid_done", awvalid_o, 0);
    chk("wvalid_done", wvalid_o, 0);
    chk("bready_on", bready_o, 1);
    if (!no_b) begin
      k = 0;
      bvalid_i = 1'b1;
      bresp_i  = br;
      while (!bready_o && k < 100) begin tick; k++; end
      tick;
      bvalid_i = 1'b0;
      sched('{w: 1'b1, to: 1'b0, resp: br, data: 32'h0}, cyc + 1);
    end
  endtask

  task automatic do_read(input logic [31:0] a, input int ard,
                         input int rdl, input logic [31:0] rd,
                         input logic [1:0] rr, input bit hang,
                         input bit pop_at_push, output int acc);
    int k = 0;
    bit arh = 0, rh = 0;
    send(1'b0, a, 32'h0, 4'h0);
    acc = cyc;
    chk("arvalid_start", arvalid_o, 1);
    chk("araddr", araddr_o, a);
    chk("arsize", arsize_o, 3'd2);
    if (hang) begin
      sched('{w: 1'b0, to: 1'b1, resp: 2'b10, data: 32'h0}, acc + T + 1);
      while (arvalid_o && k < 100) begin tick; k++; end
      chk("ar_valid_cycles", k, T);
      rvalid_i = 1'b1;
      rdata_i  = 32'hBAD0BAD0;
      chk("rready_after_abort", rready_o, 0);
      tick;
      chk("rready_late_r", rready_o, 0);
      chk("req_ready_after_abort", req_ready_o, 1);
      rvalid_i = 1'b0;
    end else begin
      while (!arh && k < 100) begin
        arready_i = (k >= ard);
        if (arvalid_o && arready_i) arh = 1;
        tick;
        k++;
      end
      arready_i = 1'b0;
      if (!arh) bound_fail("ar_phase");
      k = 0;
      while (!rh && k < 100) begin
        rvalid_i = (k >= rdl);
        rdata_i  = rd;
        rresp_i  = rr;
        if (rvalid_i && rready_o) rh = 1;
        tick;
        k++;
      end
      rvalid_i = 1'b0;
      if (!rh) bound_fail("r_phase");
      sched('{w: 1'b0, to: 1'b0, resp: rr, data: rd}, cyc + 1);
      if (pop_at_push) pop1;
    end
  endtask

  int acc0, acc1;

  initial begin
    ares_axi = 1'b1;
    req_valid_i = 0; req_write_i = 0; req_addr_i = 0;
    req_data_i = 0; req_wstrb_i = 0; req_size_i = 0;
    awready_i = 0; wready_i = 0; bvalid_i = 0; bresp_i = 0;
    arready_i = 0; rvalid_i = 0; rdata_i = 0; rresp_i = 0;
    rlast_i = 1'b1; sts_pop_i = 0;
    repeat (3) tick;
    ares_axi = 1'b0;
    chk("rst_awvalid", awvalid_o, 0);
    chk("rst_wvalid", wvalid_o, 0);
    chk("rst_bready", bready_o, 0);
    chk("rst_arvalid", arvalid_o, 0);
    chk("rst_rready", rready_o, 0);
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_sts", {sts_valid_o, sts_slots_o, sts_data_o,
                    sts_resp_o, sts_timeout_o, sts_write_o}, 0);
    tick;

    do_write(32'h1000, 32'hDEADBEEF, 4'hF, 0, 3, 2'b00, 0);
    chk("aw_hs_count", aw_hs, 1);
    chk("w_hs_count", w_hs, 1);
    tick;
    chk("wr_entry", {sts_write_o, sts_timeout_o, sts_resp_o,
                     sts_data_o}, {1'b1, 1'b0, 2'b00, 32'h0});
    chk("wr_slots", sts_slots_o, 1);
    do_write(32'h1004, 32'h0BADF00D, 4'h3, 2, 0, 2'b01, 0);
    chk("aw_hs_count2", aw_hs, 1);
    do_write(32'h1008, 32'h55AA55AA, 4'h8, 0, 0, 2'b11, 0);
    chk("w_hs_count3", w_hs, 1);
    tick;
    chk("three_slots", sts_slots_o, 3);
    repeat (3) pop1;

    do_read(32'h2000, 1, 2, 32'h12345678, 2'b10, 0, 0, acc0);
    tick;
    chk("rd_entry", {sts_write_o, sts_timeout_o, sts_resp_o,
                     sts_data_o}, {1'b0, 1'b0, 2'b10, 32'h12345678});
    pop1;
    chk("rd_popped_valid", sts_valid_o, 0);

    do_read(32'h3000, 0, 0, 32'h0, 2'b00, 1, 0, acc0);
    chk("to_entry", {sts_timeout_o, sts_resp_o, sts_data_o},
        {1'b1, 2'b10, 32'h0});
    pop1;

    do_read(32'hA000, 0, 0, 32'hA0000001, 2'b00, 0, 0, acc0);
    do_read(32'hA004, 0, 0, 32'hA0000002, 2'b00, 0, 0, acc1);
    chk("b2b_cadence", acc1 - acc0, 4);
    do_read(32'hA008, 0, 0, 32'hA0000003, 2'b01, 0, 0, acc0);
    do_read(32'hA00C, 0, 0, 32'hA0000004, 2'b00, 0, 0, acc0);
    tick;
    chk("full_ready", req_ready_o, 0);
    chk("full_slots", sts_slots_o, 4);
    tick;
    chk("full_ready_hold", req_ready_o, 0);
    pop1;
    chk("after_pop_slots", sts_slots_o, 3);
    do_read(32'hA010, 0, 1, 32'hA0000005, 2'b00, 0, 1, acc0);
    chk("push_pop_slots", sts_slots_o, 3);
    chk("order3", sts_data_o, 32'hA0000003);
    chk("order3_resp", sts_resp_o, 2'b01);
    pop1;
    chk("order4", sts_data_o, 32'hA0000004);
    pop1;
    chk("order5", sts_data_o, 32'hA0000005);
    pop1;
    chk("drained", sts_valid_o, 0);
    pop1;
    chk("empty_pop_slots", sts_slots_o, 0);

    do_read(32'hB000, 0, 0, 32'hB1, 2'b00, 0, 0, acc0);
    do_read(32'hB004, 0, 0, 32'hB2, 2'b00, 0, 0, acc0);
    do_write(32'hB008, 32'h1, 4'h1, 0, 0, 2'b00, 1);
    chk("held_two", sts_slots_o, 2);
    ares_axi = 1'b1;
    tick;
    ares_axi = 1'b0;
    chk("mid_rst_axi", {awvalid_o, wvalid_o, bready_o,
                        arvalid_o, rready_o}, 0);
    chk("mid_rst_slots", sts_slots_o, 0);
    chk("mid_rst_req_ready", req_ready_o, 1);
    do_read(32'hC000, 0, 0, 32'hC0FFEE, 2'b00, 0, 0, acc0);
    repeat (3) tick;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
